// File: rtl/cu_microsequencer.sv
// Microprogrammed control-unit sequencer: next-address CAR, CBR, micro-stack.
// Supports branch, dispatch, call/return, memory stall and halt/resume.
module cu_microsequencer #(
  parameter  int CAR_W       = 7,
  parameter  int CTRL_W      = 16,
  parameter  int ALU_OP_W    = 4,
  parameter  int OPC_W       = 5,
  parameter  int STACK_DEPTH = 4,
  localparam int UW_W        = CTRL_W + ALU_OP_W + 2 + 3 + 3 + CAR_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [UW_W-1:0]     i_uword,
  input  logic [OPC_W-1:0]    i_opcode,
  input  logic [4:0]          i_flags,
  input  logic                i_stall,
  input  logic                i_resume,
  output logic [CAR_W-1:0]    o_car,
  output logic [CTRL_W-1:0]   o_ctrl,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_mar_inc,
  output logic                o_IF_stage,
  output logic                o_halt,
  output logic                o_err
);

  localparam int A_LO  = CTRL_W;
  localparam int M_B   = CTRL_W + ALU_OP_W;
  localparam int H_B   = M_B + 1;
  localparam int C_LO  = H_B + 1;
  localparam int S_LO  = C_LO + 3;
  localparam int D_LO  = S_LO + 3;
  localparam int CBR_W = H_B + 1;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    SQ_NEXT   = 3'd0,
    SQ_JUMP   = 3'd1,
    SQ_BRANCH = 3'd2,
    SQ_MAP    = 3'd3,
    SQ_CALL   = 3'd4,
    SQ_RET    = 3'd5,
    SQ_FETCH  = 3'd6,
    SQ_RSV    = 3'd7
  } seq_t;

  state_t             state_q, state_d;
  logic [CAR_W-1:0]   car_q, car_d;
  logic [CBR_W-1:0]   cbr_q, cbr_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic               err_q, err_d;
  logic [CAR_W-1:0]   stack [STACK_DEPTH];

  seq_t               u_seq;
  logic [2:0]         u_cond;
  logic [CAR_W-1:0]   u_addr;
  logic [CAR_W-1:0]   car_inc;
  logic [CAR_W-1:0]   map_addr;
  logic [CAR_W-1:0]   seq_car;
  logic [IX_W-1:0]    wr_idx;
  logic [IX_W-1:0]    rd_idx;
  logic               cond_ok;
  logic               push, pop;
  logic               stk_err, rsv_err;
  logic               advance;
  logic               do_push;
  logic               active;
  logic               zf, cf, of, nf, mf;

  assign {zf, cf, of, nf, mf} = i_flags;

  assign u_seq   = seq_t'(i_uword[S_LO +: 3]);
  assign u_cond  = i_uword[C_LO +: 3];
  assign u_addr  = i_uword[D_LO +: CAR_W];
  assign car_inc = car_q + 1'b1;
  assign wr_idx  = IX_W'(sp_q);
  assign rd_idx  = IX_W'(sp_q - 1'b1);

  always_comb begin
    map_addr = '0;
    map_addr[OPC_W+1:0] = {i_opcode, 2'b00};
  end

  always_comb begin
    cond_ok = 1'b1;
    case (u_cond)
      3'd0:    cond_ok = 1'b1;
      3'd1:    cond_ok = zf;
      3'd2:    cond_ok = cf;
      3'd3:    cond_ok = of;
      3'd4:    cond_ok = nf;
      3'd5:    cond_ok = mf;
      3'd6:    cond_ok = ~zf;
      default: cond_ok = ~cf;
    endcase
  end

  // Next address for the word at o_car, plus its stack side effects.
  always_comb begin
    seq_car = car_inc;
    push    = 1'b0;
    pop     = 1'b0;
    stk_err = 1'b0;
    rsv_err = 1'b0;
    unique case (u_seq)
      SQ_NEXT:   seq_car = car_inc;
      SQ_JUMP:   seq_car = u_addr;
      SQ_BRANCH: seq_car = cond_ok ? u_addr : car_inc;
      SQ_MAP:    seq_car = map_addr;
      SQ_CALL: begin
        if (sp_q == SP_W'(STACK_DEPTH)) begin
          stk_err = 1'b1;
        end else begin
          push    = 1'b1;
          seq_car = u_addr;
        end
      end
      SQ_RET: begin
        if (sp_q == '0) begin
          stk_err = 1'b1;
        end else begin
          pop     = 1'b1;
          seq_car = stack[rd_idx];
        end
      end
      SQ_FETCH:  seq_car = '0;
      SQ_RSV:    rsv_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    car_d   = car_q;
    cbr_d   = cbr_q;
    sp_d    = sp_q;
    err_d   = err_q;
    advance = 1'b0;
    do_push = 1'b0;
    if (!i_stall) begin
      unique case (state_q)
        S_RUN: begin
          if (cbr_q[H_B]) state_d = S_HALT;
          else            advance = 1'b1;
        end
        S_HALT: begin
          if (i_resume && !err_q) begin
            state_d = S_RUN;
            advance = 1'b1;
          end
        end
      endcase
    end
    if (advance) begin
      if (stk_err) begin
        err_d   = 1'b1;
        cbr_d   = '0;
        state_d = S_HALT;
      end else begin
        cbr_d   = i_uword[CBR_W-1:0];
        car_d   = seq_car;
        do_push = push;
        if (push)    sp_d  = sp_q + 1'b1;
        if (pop)     sp_d  = sp_q - 1'b1;
        if (rsv_err) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RUN;
      car_q   <= '0;
      cbr_q   <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      car_q   <= car_d;
      cbr_q   <= cbr_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Return addresses need no reset: sp_q gates every read.
  always_ff @(posedge i_clk) begin
    if (do_push) stack[wr_idx] <= car_inc;
  end

  assign active     = (state_q == S_RUN) && !i_stall;
  assign o_car      = car_q;
  assign o_ctrl     = active ? cbr_q[CTRL_W-1:0] : '0;
  assign o_alu_op   = active ? cbr_q[A_LO +: ALU_OP_W] : '0;
  assign o_mar_inc  = active & cbr_q[M_B];
  assign o_IF_stage = o_ctrl[2];
  assign o_halt     = (state_q == S_HALT) | cbr_q[H_B];
  assign o_err      = err_q;

endmodule

// File: tb/tb_cu_microsequencer.sv
// Scoreboard bench for cu_microsequencer: ROM model plus
// per-cycle expected CAR/strobe/halt/error values.
module tb_cu_microsequencer;

  localparam int UW_W = 35;

  logic        clk;
  logic        rst_n;
  logic [34:0] uword;
  logic [4:0]  opcode;
  logic [4:0]  flags;
  logic        stall;
  logic        resume;
  logic [6:0]  car;
  logic [15:0] ctrl;
  logic [3:0]  alu;
  logic        mar;
  logic        if_st;
  logic        halt;
  logic        err;

  logic [34:0] rom [128];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        stall;
    logic        resume;
    logic [4:0]  flags;
    logic [6:0]  car;
    logic [15:0] ctrl;
    logic [3:0]  alu;
    logic        mar;
    logic        halt;
    logic        err;
  } ent_t;

  ent_t sbq[$];

  assign uword = rom[car];

  cu_microsequencer dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_uword    (uword),
    .i_opcode   (opcode),
    .i_flags    (flags),
    .i_stall    (stall),
    .i_resume   (resume),
    .o_car      (car),
    .o_ctrl     (ctrl),
    .o_alu_op   (alu),
    .o_mar_inc  (mar),
    .o_IF_stage (if_st),
    .o_halt     (halt),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [34:0] mk(
    input logic [15:0] c, input logic [3:0] a,
    input logic m, input logic h,
    input logic [2:0] cd, input logic [2:0] sq,
    input logic [6:0] ad);
    return {ad, sq, cd, h, m, a, c};
  endfunction

  task automatic push(
    input logic st, input logic rs, input logic [4:0] fl,
    input logic [6:0] c, input logic [15:0] ct,
    input logic [3:0] a, input logic m,
    input logic h, input logic e);
    ent_t x;
    x.stall = st; x.resume = rs; x.flags = fl;
    x.car = c; x.ctrl = ct; x.alu = a; x.mar = m;
    x.halt = h; x.err = e;
    sbq.push_back(x);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    stall  = 1'b0;
    resume = 1'b0;
    flags  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = mk(16'hFFFF, 4'hF, 1, 0, 0, 3'd1, 7'd9);
    opcode = '0;
    do_reset();
    @(posedge clk); #1;
    total++;
    if (car !== 7'd9 || ctrl !== 16'hFFFF) begin
      bad++;
      $display("FAIL reset_pre car=%h ctrl=%h want 09/ffff", car, ctrl);
    end
    rst_n = 1'b0; #1;
    total++;
    if ({car, ctrl, alu, mar, halt, err} !== '0) begin
      bad++;
      $display("FAIL reset_async car=%h ctrl=%h alu=%h mar=%b halt=%b err=%b want 0",
               car, ctrl, alu, mar, halt, err);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if (car !== 7'd0 || ctrl !== 16'h0 || halt !== 1'b0) begin
      bad++;
      $display("FAIL reset_release car=%h ctrl=%h halt=%b want 0", car, ctrl, halt);
    end
  endtask

  task automatic test_next_jump();
    ent_t e;
    clear_rom();
    rom[0] = mk(16'h0001, 4'd3, 0, 0, 0, 3'd0, 7'd0);
    rom[1] = mk(16'h0002, 4'd0, 1, 0, 0, 3'd1, 7'd5);
    rom[5] = mk(16'h0020, 4'd0, 0, 0, 0, 3'd0, 7'd0);
    rom[6] = mk(16'h0040, 4'd0, 0, 0, 0, 3'd7, 7'd0);
    do_reset();
    push(0, 0, 0, 7'd1, 16'h0001, 4'd3, 0, 0, 0);
    push(0, 0, 0, 7'd5, 16'h0002, 4'd0, 1, 0, 0);
    push(0, 0, 0, 7'd6, 16'h0020, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd7, 16'h0040, 4'd0, 0, 0, 1);
    push(0, 0, 0, 7'd8, 16'h0000, 4'd0, 0, 0, 1);
    for (int n = 1; sbq.size() > 0; n++) begin
      e = sbq.pop_front();
      @(posedge clk); #1;
      stall = e.stall; resume = e.resume; flags = e.flags;
      @(negedge clk);
      total++;
      if (car !== e.car || ctrl !== e.ctrl || alu !== e.alu ||
          mar !== e.mar || halt !== e.halt || err !== e.err ||
          if_st !== e.ctrl[2]) begin
        bad++;
        $display("FAIL next_jump c%0d car=%h/%h ctrl=%h/%h alu=%h/%h mar=%b/%b halt=%b/%b err=%b/%b",
                 n, car, e.car, ctrl, e.ctrl, alu, e.alu, mar, e.mar,
                 halt, e.halt, err, e.err);
      end
    end
  endtask

  task automatic test_branch();
    ent_t e;
    logic [2:0]  cd  [4] = '{3'd1, 3'd1, 3'd6, 3'd6};
    logic        zf  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [6:0]  tgt [4] = '{7'd20, 7'd6, 7'd6, 7'd20};
    logic [15:0] tc  [4] = '{16'h0100, 16'h0200, 16'h0200, 16'h0100};
    for (int v = 0; v < 4; v++) begin
      clear_rom();
      rom[0]  = mk(16'h0001, 4'd0, 0, 0, 0, 3'd1, 7'd5);
      rom[5]  = mk(16'h0004, 4'd0, 0, 0, cd[v], 3'd2, 7'd20);
      rom[6]  = mk(16'h0200, 4'd0, 0, 0, 0, 3'd0, 7'd0);
      rom[20] = mk(16'h0100, 4'd0, 0, 0, 0, 3'd0, 7'd0);
      do_reset();
      push(0, 0, {zf[v], 4'b0}, 7'd5, 16'h0001, 4'd0, 0, 0, 0);
      push(0, 0, 5'b0, tgt[v], 16'h0004, 4'd0, 0, 0, 0);
      push(0, 0, 5'b0, tgt[v] + 7'd1, tc[v], 4'd0, 0, 0, 0);
      for (int n = 1; sbq.size() > 0; n++) begin
        e = sbq.pop_front();
        @(posedge clk); #1;
        stall = e.stall; resume = e.resume; flags = e.flags;
        @(negedge clk);
        total++;
        if (car !== e.car || ctrl !== e.ctrl || halt !== e.halt ||
            err !== e.err || if_st !== e.ctrl[2]) begin
          bad++;
          $display("FAIL branch v%0d c%0d car=%h/%h ctrl=%h/%h if=%b",
                   v, n, car, e.car, ctrl, e.ctrl, if_st);
        end
      end
    end
  endtask

  task automatic test_map_call();
    ent_t e;
    clear_rom();
    rom[0]  = mk(16'h0001, 4'd0, 0, 0, 0, 3'd3, 7'd0);
    rom[44] = mk(16'h0002, 4'd0, 0, 0, 0, 3'd1, 7'd10);
    rom[10] = mk(16'h0004, 4'd0, 0, 0, 0, 3'd4, 7'd40);
    rom[40] = mk(16'h0008, 4'd0, 0, 0, 0, 3'd5, 7'd0);
    rom[11] = mk(16'h0010, 4'd0, 0, 0, 0, 3'd5, 7'd0);
    opcode = 5'h0B;
    do_reset();
    push(0, 0, 0, 7'h2C, 16'h0001, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd10, 16'h0002, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd40, 16'h0004, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd11, 16'h0008, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd11, 16'h0000, 4'd0, 0, 1, 1);
    push(0, 1, 0, 7'd11, 16'h0000, 4'd0, 0, 1, 1);
    push(0, 0, 0, 7'd11, 16'h0000, 4'd0, 0, 1, 1);
    for (int n = 1; sbq.size() > 0; n++) begin
      e = sbq.pop_front();
      @(posedge clk); #1;
      stall = e.stall; resume = e.resume; flags = e.flags;
      @(negedge clk);
      total++;
      if (car !== e.car || ctrl !== e.ctrl || halt !== e.halt ||
          err !== e.err) begin
        bad++;
        $display("FAIL map_call c%0d car=%h/%h ctrl=%h/%h halt=%b/%b err=%b/%b",
                 n, car, e.car, ctrl, e.ctrl, halt, e.halt, err, e.err);
      end
    end
    opcode = '0;
  endtask

  task automatic test_overflow();
    ent_t e;
    clear_rom();
    rom[0]  = mk(16'h0001, 4'd0, 0, 0, 0, 3'd4, 7'd10);
    rom[10] = mk(16'h0002, 4'd0, 0, 0, 0, 3'd4, 7'd20);
    rom[20] = mk(16'h0004, 4'd0, 0, 0, 0, 3'd4, 7'd30);
    rom[30] = mk(16'h0008, 4'd0, 0, 0, 0, 3'd4, 7'd40);
    rom[40] = mk(16'h0010, 4'd0, 0, 0, 0, 3'd4, 7'd50);
    do_reset();
    push(0, 0, 0, 7'd10, 16'h0001, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd20, 16'h0002, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd30, 16'h0004, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd40, 16'h0008, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd40, 16'h0000, 4'd0, 0, 1, 1);
    push(0, 1, 0, 7'd40, 16'h0000, 4'd0, 0, 1, 1);
    push(0, 0, 0, 7'd40, 16'h0000, 4'd0, 0, 1, 1);
    for (int n = 1; sbq.size() > 0; n++) begin
      e = sbq.pop_front();
      @(posedge clk); #1;
      stall = e.stall; resume = e.resume; flags = e.flags;
      @(negedge clk);
      total++;
      if (car !== e.car || ctrl !== e.ctrl || halt !== e.halt ||
          err !== e.err) begin
        bad++;
        $display("FAIL overflow c%0d car=%h/%h ctrl=%h/%h halt=%b/%b err=%b/%b",
                 n, car, e.car, ctrl, e.ctrl, halt, e.halt, err, e.err);
      end
    end
    rst_n = 1'b0; #1;
    total++;
    if (car !== 7'd0 || halt !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL overflow_reset car=%h halt=%b err=%b want 0", car, halt, err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stall();
    ent_t e;
    clear_rom();
    for (int i = 0; i < 8; i++)
      rom[i] = mk(16'(1 << i), 4'd0, 0, 0, 0, 3'd0, 7'd0);
    rom[1] = mk(16'h0002, 4'd5, 1, 0, 0, 3'd0, 7'd0);
    do_reset();
    push(0, 0, 0, 7'd1, 16'h0001, 4'd0, 0, 0, 0);
    push(1, 0, 0, 7'd2, 16'h0000, 4'd0, 0, 0, 0);
    push(1, 1, 0, 7'd2, 16'h0000, 4'd0, 0, 0, 0);
    push(1, 0, 0, 7'd2, 16'h0000, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd2, 16'h0002, 4'd5, 1, 0, 0);
    push(0, 0, 0, 7'd3, 16'h0004, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd4, 16'h0008, 4'd0, 0, 0, 0);
    for (int n = 1; sbq.size() > 0; n++) begin
      e = sbq.pop_front();
      @(posedge clk); #1;
      stall = e.stall; resume = e.resume; flags = e.flags;
      #1;
      @(negedge clk);
      total++;
      if (car !== e.car || ctrl !== e.ctrl || alu !== e.alu ||
          mar !== e.mar || halt !== e.halt || err !== e.err) begin
        bad++;
        $display("FAIL stall c%0d car=%h/%h ctrl=%h/%h alu=%h/%h mar=%b/%b",
                 n, car, e.car, ctrl, e.ctrl, alu, e.alu, mar, e.mar);
      end
    end
  endtask

  task automatic test_halt_resume();
    ent_t e;
    clear_rom();
    rom[0] = mk(16'h0001, 4'd0, 0, 0, 0, 3'd0, 7'd0);
    rom[1] = mk(16'h0020, 4'd0, 0, 1, 0, 3'd0, 7'd0);
    rom[2] = mk(16'h0040, 4'd0, 0, 0, 0, 3'd0, 7'd0);
    rom[3] = mk(16'h0080, 4'd0, 0, 0, 0, 3'd0, 7'd0);
    do_reset();
    push(0, 0, 0, 7'd1, 16'h0001, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd2, 16'h0020, 4'd0, 0, 1, 0);
    push(0, 0, 0, 7'd2, 16'h0000, 4'd0, 0, 1, 0);
    push(1, 1, 0, 7'd2, 16'h0000, 4'd0, 0, 1, 0);
    push(0, 0, 0, 7'd2, 16'h0000, 4'd0, 0, 1, 0);
    push(0, 1, 0, 7'd2, 16'h0000, 4'd0, 0, 1, 0);
    push(0, 0, 0, 7'd3, 16'h0040, 4'd0, 0, 0, 0);
    push(0, 0, 0, 7'd4, 16'h0080, 4'd0, 0, 0, 0);
    for (int n = 1; sbq.size() > 0; n++) begin
      e = sbq.pop_front();
      @(posedge clk); #1;
      stall = e.stall; resume = e.resume; flags = e.flags;
      @(negedge clk);
      total++;
      if (car !== e.car || ctrl !== e.ctrl || halt !== e.halt ||
          err !== e.err) begin
        bad++;
        $display("FAIL halt c%0d car=%h/%h ctrl=%h/%h halt=%b/%b err=%b/%b",
                 n, car, e.car, ctrl, e.ctrl, halt, e.halt, err, e.err);
      end
    end
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (halt !== 1'b1 || car !== 7'd2) begin
      bad++;
      $display("FAIL halt_pre car=%h halt=%b want 02/1", car, halt);
    end
    rst_n = 1'b0; #1;
    total++;
    if (car !== 7'd0 || halt !== 1'b0 || ctrl !== 16'h0) begin
      bad++;
      $display("FAIL halt_reset car=%h halt=%b ctrl=%h want 0", car, halt, ctrl);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    stall  = 1'b0;
    resume = 1'b0;
    flags  = '0;
    opcode = '0;
    clear_rom();
    test_reset();
    test_next_jump();
    test_branch();
    test_map_call();
    test_overflow();
    test_stall();
    test_halt_resume();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
